proc_cmd_sched: RTL and testbench

PROC_CMD_SCHED -- requirements
Module: proc_cmd_sched

---
 rtl/proc_cmd_sched.sv | 111 +++++++++++
 tb/tb_proc_cmd_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_cmd_sched.sv
// Command scheduler: queues host commands in a small FIFO and issues them one at
// a time to a processor, with completion capture, watchdog abort and sticky errors.
module proc_cmd_sched #(
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic        clk,
   input  logic        nRESET,
   input  logic        cmd_wr,
   input  logic [3:0]  cmd_in,
   input  logic        err_clr,
   input  logic        proc_done,
   input  logic [31:0] proc_dout,
   output logic        proc_start,
   output logic [3:0]  proc_cmd,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        busy,
   output logic [4:0]  fifo_count,
   output logic        fifo_full,
   output logic        err_ovf,
   output logic        err_tmo
);

   // state  | meaning
   // IDLE   | nothing in flight; leaves as soon as the FIFO holds a command
   // ISSUE  | single cycle: start pulse, pop FIFO head, clear result_valid
   // WAIT   | command outstanding; waits for proc_done or watchdog expiry
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t          state, state_nxt;
   logic [3:0]      mem [DEPTH];
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [TW-1:0]   tmr;
   logic            cmd_ok, pop, push, drop, done_hit, tmo_hit;
   logic [4:0]      count_nxt;

   always_comb begin
      cmd_ok    = cmd_wr && (cmd_in != 4'h0);
      pop       = (state == S_ISSUE);
      push      = cmd_ok && (!fifo_full || pop);
      drop      = cmd_ok && fifo_full && !pop;
      done_hit  = (state == S_WAIT) && proc_done;
      // Completion on the expiry cycle takes priority over the abort.
      tmo_hit   = (state == S_WAIT) && !proc_done && (tmr == '0);
      count_nxt = 5'(fifo_count + {4'b0, push} - {4'b0, pop});
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (fifo_count != 5'd0) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (done_hit || tmo_hit) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      proc_start = (state == S_ISSUE);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd_in;
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         fifo_count   <= 5'd0;
         fifo_full    <= 1'b0;
         busy         <= 1'b0;
         proc_cmd     <= 4'h0;
         tmr          <= '0;
         result       <= 32'h0;
         result_valid <= 1'b0;
         err_ovf      <= 1'b0;
         err_tmo      <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= count_nxt;
         fifo_full  <= (count_nxt == 5'(DEPTH));
         busy       <= (count_nxt != 5'd0) || (state_nxt != S_IDLE);
         // Head is latched on the way into ISSUE so proc_cmd is valid with the start pulse.
         if (state == S_IDLE && fifo_count != 5'd0) proc_cmd <= mem[rd_ptr];
         if (state == S_ISSUE)                    tmr <= TW'(TIMEOUT_CYC - 1);
         else if (state == S_WAIT && tmr != '0)   tmr <= tmr - 1'b1;
         if (done_hit) begin
            result       <= proc_dout;
            result_valid <= 1'b1;
         end else if (pop) begin
            result_valid <= 1'b0;
         end
         if (drop)         err_ovf <= 1'b1;
         else if (err_clr) err_ovf <= 1'b0;
         if (tmo_hit)      err_tmo <= 1'b1;
         else if (err_clr) err_tmo <= 1'b0;
      end
   end

endmodule

// File: tb/tb_proc_cmd_sched.sv
// Bench for proc_cmd_sched: directed scenarios plus random traffic, all checked
// against a queue-based transaction model of the scheduler.
module tb_proc_cmd_sched;
   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic        clk = 1'b0;
   logic        nRESET = 1'b0;
   logic        cmd_wr = 1'b0;
   logic [3:0]  cmd_in = 4'h0;
   logic        err_clr = 1'b0;
   logic        proc_done = 1'b0;
   logic [31:0] proc_dout = 32'h0;
   logic        proc_start, result_valid, busy, fifo_full, err_ovf, err_tmo;
   logic [3:0]  proc_cmd;
   logic [31:0] result;
   logic [4:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   proc_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .nRESET(nRESET), .cmd_wr(cmd_wr), .cmd_in(cmd_in),
      .err_clr(err_clr), .proc_done(proc_done), .proc_dout(proc_dout),
      .proc_start(proc_start), .proc_cmd(proc_cmd), .result(result),
      .result_valid(result_valid), .busy(busy), .fifo_count(fifo_count),
      .fifo_full(fifo_full), .err_ovf(err_ovf), .err_tmo(err_tmo)
   );

   always #5 clk = ~clk;

   // Model: pending queue, an issue-this-cycle flag, and an outstanding command
   // with the number of cycles it has been waiting.
   logic [3:0]  q[$];
   bit          m_issuing, m_wait, m_rv, m_ovf, m_tmo;
   int          m_waited;
   logic [3:0]  m_cmd;
   logic [31:0] m_result;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_issuing = 0; m_wait = 0; m_rv = 0; m_ovf = 0; m_tmo = 0;
      m_waited = 0; m_cmd = 4'h0; m_result = 32'h0;
   endfunction

   function automatic void model_step(bit wr, logic [3:0] c, bit clr, bit done, logic [31:0] dout);
      int sz  = q.size();
      bit pop = m_issuing;
      bit ovf = 0;
      bit tmo = 0;
      if (m_issuing) begin
         void'(q.pop_front());
         m_rv = 0; m_issuing = 0; m_wait = 1; m_waited = 0;
      end else if (m_wait) begin
         m_waited++;
         if (done) begin
            m_result = dout; m_rv = 1; m_wait = 0;
         end else if (m_waited == TMO) begin
            tmo = 1; m_wait = 0;
         end
      end else if (sz != 0) begin
         m_issuing = 1; m_cmd = q[0];
      end
      if (wr && c != 4'h0) begin
         if (sz < DEPTH || pop) q.push_back(c);
         else ovf = 1;
      end
      m_ovf = ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_tmo = tmo ? 1'b1 : (clr ? 1'b0 : m_tmo);
   endfunction

   task automatic compare_all();
      chk("proc_start",   32'(proc_start),   32'(m_issuing));
      chk("proc_cmd",     32'(proc_cmd),     32'(m_cmd));
      chk("result",       result,            m_result);
      chk("result_valid", 32'(result_valid), 32'(m_rv));
      chk("busy",         32'(busy),         32'(q.size() != 0 || m_issuing || m_wait));
      chk("fifo_count",   32'(fifo_count),   32'(q.size()));
      chk("fifo_full",    32'(fifo_full),    32'(q.size() == DEPTH));
      chk("err_ovf",      32'(err_ovf),      32'(m_ovf));
      chk("err_tmo",      32'(err_tmo),      32'(m_tmo));
   endtask

   task automatic cyc(input bit wr, input logic [3:0] c, input bit clr, input bit done,
                      input logic [31:0] dout);
      cmd_wr = wr; cmd_in = c; err_clr = clr; proc_done = done; proc_dout = dout;
      @(negedge clk);
      compare_all();
      model_step(wr, c, clr, done, dout);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_start"}, 32'(proc_start), 32'h0);
      chk({tag, "_cmd"},   32'(proc_cmd),   32'h0);
      chk({tag, "_res"},   result,          32'h0);
      chk({tag, "_rv"},    32'(result_valid), 32'h0);
      chk({tag, "_busy"},  32'(busy),       32'h0);
      chk({tag, "_cnt"},   32'(fifo_count), 32'h0);
      chk({tag, "_full"},  32'(fifo_full),  32'h0);
      chk({tag, "_ovf"},   32'(err_ovf),    32'h0);
      chk({tag, "_tmo"},   32'(err_tmo),    32'h0);
   endtask

   // Pulse proc_done every cycle until the scheduler goes quiet.
   task automatic drain();
      int n = 0;
      while (busy && n < 80) begin
         cyc(1'b0, 4'h0, 1'b0, 1'b1, 32'($urandom));
         n++;
      end
      chk("drain_busy", 32'(busy), 32'h0);
   endtask

   initial begin
      logic [31:0] saved;
      model_reset();
      #2;
      check_reset_values("por");
      @(posedge clk); #1;
      nRESET = 1'b1;
      idle(2);

      // Single command latency and completion capture.
      cyc(1'b1, 4'h3, 1'b0, 1'b0, 32'h0);
      idle(1);
      chk("sc_start", 32'(proc_start), 32'h1);
      chk("sc_cmd",   32'(proc_cmd),   32'h3);
      idle(3);
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 32'h00123456);
      chk("sc_result", result, 32'h00123456);
      chk("sc_rv",     32'(result_valid), 32'h1);
      chk("sc_busy",   32'(busy), 32'h0);

      // Overflow with a stalled processor, then strict in-order issue.
      for (int i = 1; i <= 6; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0, 32'h0);
      chk("ovf_full", 32'(fifo_full), 32'h1);
      chk("ovf_cnt",  32'(fifo_count), 32'h4);
      chk("ovf_err",  32'(err_ovf), 32'h1);
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 32'h11);
      for (int k = 2; k <= 5; k++) begin
         int n = 0;
         while (!proc_start && n < 5) begin idle(1); n++; end
         chk("ovf_start", 32'(proc_start), 32'h1);
         chk("ovf_order", 32'(proc_cmd), 32'(k));
         idle(2);
         cyc(1'b0, 4'h0, 1'b0, 1'b1, 32'(k));
      end
      drain();
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("ovf_clr", 32'(err_ovf), 32'h0);

      // Watchdog abort after exactly TMO wait cycles, then clear.
      saved = result;
      cyc(1'b1, 4'h7, 1'b0, 1'b0, 32'h0);
      idle(9);
      chk("tmo_early", 32'(err_tmo), 32'h0);
      idle(1);
      chk("tmo_set",  32'(err_tmo), 32'h1);
      chk("tmo_rv",   32'(result_valid), 32'h0);
      chk("tmo_res",  result, saved);
      chk("tmo_busy", 32'(busy), 32'h0);
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 32'h0);
      chk("tmo_clr", 32'(err_tmo), 32'h0);

      // Completion on the expiry cycle wins over the abort.
      cyc(1'b1, 4'h5, 1'b0, 1'b0, 32'h0);
      idle(9);
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 32'hCAFE0005);
      chk("edge_tmo", 32'(err_tmo), 32'h0);
      chk("edge_rv",  32'(result_valid), 32'h1);
      chk("edge_res", result, 32'hCAFE0005);

      // Full FIFO accepts a write in the ISSUE cycle.
      for (int i = 1; i <= 5; i++) cyc(1'b1, 4'(i + 8), 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 32'h9);
      idle(1);
      chk("fp_issue", 32'(proc_start), 32'h1);
      cyc(1'b1, 4'hF, 1'b0, 1'b0, 32'h0);
      chk("fp_cnt", 32'(fifo_count), 32'h4);
      chk("fp_ovf", 32'(err_ovf), 32'h0);
      drain();

      // NOP writes and stray done.
      saved = result;
      cyc(1'b1, 4'h0, 1'b0, 1'b0, 32'h0);
      chk("nop_cnt", 32'(fifo_count), 32'h0);
      idle(1);
      chk("nop_start", 32'(proc_start), 32'h0);
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF);
      chk("stray_res", result, saved);

      // Reset in WAIT with two commands queued.
      cyc(1'b1, 4'h1, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 4'h2, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 4'h3, 1'b0, 1'b0, 32'h0);
      chk("mid_cnt", 32'(fifo_count), 32'h2);
      nRESET = 1'b0;
      #1;
      check_reset_values("mid");
      model_reset();
      @(posedge clk); #1;
      nRESET = 1'b1;
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 32'h12345678);
      idle(4);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 3) == 0, 4'($urandom), ($urandom % 20) == 0,
             ($urandom % 5) == 0, 32'($urandom));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
